// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and the baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  // Nearest-integer clocks per bit.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side valid/ready handshake carrying one UART payload word.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: free-running modulo DIV, synchronously clearable, tick on the last count.
module uart_baud_gen #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits,
// with zero-gap chaining when a new word is offered on the last stop cycle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int      CLK_HZ    = 100_000_000,
  parameter int      BAUD      = 115_200,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_frame_if.slave bus,
  output logic           tx,
  output logic           busy,
  output logic           tx_done
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: baud divisor must be at least 2");
  end

  tx_state_e            state, state_n;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q;
  logic                 tx_q, tx_n;
  logic                 tick, accept, last_stop, frame_end;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .tick    (tick)
  );

  assign last_stop    = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end    = (state == STOP) && last_stop && tick;
  assign bus.tx_ready = (state == IDLE) || frame_end;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign busy         = (state != IDLE);
  assign tx_done      = frame_end;
  assign tx           = tx_q;

  // The line level is derived from the next state so tx changes on the same edge as the state.
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    tx_n    = 1'b1;
    if (accept) begin
      shift_n = bus.tx_data;
    end else if (state == DATA && tick) begin
      shift_n = shift_q >> 1;
    end
    case (state)
      IDLE:   if (accept) state_n = START;
      START:  if (tick) state_n = DATA;
      DATA:   if (tick && bit_cnt == BW'(DATA_BITS - 1))
                state_n = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
      uart_pkg::PARITY: if (tick) state_n = STOP;
      STOP:   if (frame_end) state_n = accept ? START : IDLE;
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:            tx_n = 1'b0;
      DATA:             tx_n = shift_n[0];
      uart_pkg::PARITY: tx_n = par_q;
      default:          tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_n;
      tx_q  <= tx_n;
      if (accept) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end else if (tick) begin
        if (state == DATA && bit_cnt != BW'(DATA_BITS - 1)) bit_cnt <= bit_cnt + 1'b1;
        if (state == STOP && !last_stop) stop_cnt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_n;
    if (accept) par_q <= (PARITY == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with DIV=10: four configurations share one clock and reset.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] tx_w, busy_w, done_w, ready_w;
  logic [3:0] valid_r;
  logic [7:0] data_r [4];

  int checks   = 0;
  int failures = 0;

  logic [31:0] obs;
  int glitch, busy_hi, done_cnt, done_first, done_last, ready_hits;

  uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) bus2 ();
  uart_tx_frame_if #(.DATA_BITS(5)) bus3 ();

  assign bus0.tx_data = data_r[0];
  assign bus1.tx_data = data_r[1];
  assign bus2.tx_data = data_r[2];
  assign bus3.tx_data = data_r[3][4:0];
  assign bus0.tx_valid = valid_r[0];
  assign bus1.tx_valid = valid_r[1];
  assign bus2.tx_valid = valid_r[2];
  assign bus3.tx_valid = valid_r[3];
  assign ready_w = {bus3.tx_ready, bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};

  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
    u_8n1 (.clk(clk), .reset_n(reset_n), .bus(bus0), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
    u_8e1 (.clk(clk), .reset_n(reset_n), .bus(bus1), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(2))
    u_8o2 (.clk(clk), .reset_n(reset_n), .bus(bus2), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(1))
    u_5n1 (.clk(clk), .reset_n(reset_n), .bus(bus3), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs_v, exp_v);
      end
  endtask

  // Present a word; the accept edge follows. Returns at accept edge + 1 ns.
  task automatic send(input int id, input logic [7:0] d);
    data_r[id]  = d;
    valid_r[id] = 1'b1;
    chk($sformatf("ready_before_send%0d", id), 32'(ready_w[id]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Sample one line bit per 10 clocks, plus per-cycle busy/done/ready statistics.
  task automatic watch(input int id, input int ncyc, input int drop_k, input int scr_k);
    obs = '0; glitch = 0; busy_hi = 0; done_cnt = 0;
    done_first = -1; done_last = -1; ready_hits = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if ((k - 1) % 10 == 0) obs[(k-1)/10] = tx_w[id];
      else if (tx_w[id] !== obs[(k-1)/10]) glitch++;
      if (busy_w[id] === 1'b1) busy_hi++;
      if (ready_w[id] === 1'b1) ready_hits++;
      if (done_w[id] === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = k;
        done_last = k;
      end
      if (k == drop_k) valid_r[id] = 1'b0;
      if (k == scr_k) data_r[id] = 8'hFF;
    end
  endtask

  task automatic run_frame(input string tag, input int id, input int nbits,
                           input logic [31:0] exp_bits, input int frames,
                           input int drop_k, input int scr_k);
    int ncyc;
    logic [31:0] mask;
    ncyc = nbits * 10;
    mask = (32'h1 << nbits) - 32'h1;
    watch(id, ncyc, drop_k, scr_k);
    chk({tag, "_line_bits"}, obs & mask, exp_bits);
    chk({tag, "_glitches"}, 32'(glitch), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(busy_hi), 32'(ncyc));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'(frames));
    chk({tag, "_done_first"}, 32'(done_first), 32'(ncyc / frames));
    chk({tag, "_done_last"}, 32'(done_last), 32'(ncyc));
    chk({tag, "_ready_cycles"}, 32'(ready_hits), 32'(frames));
    @(posedge clk);
    #1;
    chk({tag, "_after_busy"}, 32'(busy_w[id]), 32'd0);
    chk({tag, "_after_tx"}, 32'(tx_w[id]), 32'd1);
    chk({tag, "_after_done"}, 32'(done_w[id]), 32'd0);
    chk({tag, "_after_ready"}, 32'(ready_w[id]), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    valid_r = '0;
    for (int i = 0; i < 4; i++) data_r[i] = 8'h00;
    #5 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_tx%0d", i), 32'(tx_w[i]), 32'd1);
      chk($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("reset_ready%0d", i), 32'(ready_w[i]), 32'd1);
    end

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1 -> {stop, A5, start} = 0x34A
    send(0, 8'hA5);
    run_frame("8n1_a5", 0, 10, 32'h34A, 1, 1, 0);

    // 8E1 0x07: three ones, even parity bit 1 -> 0x60E; data churn mid-frame is ignored
    send(1, 8'h07);
    run_frame("8e1_07", 1, 11, 32'h60E, 1, 1, 30);

    // 8O2 0x07: odd parity bit 0, two stop bits -> 0xC0E
    send(2, 8'h07);
    run_frame("8o2_07", 2, 12, 32'hC0E, 1, 1, 0);

    // 5N1 with 0xDF on the producer side: only 5'h1F reaches the line -> 0x7E
    send(3, 8'hDF);
    run_frame("5n1_1f", 3, 7, 32'h7E, 1, 1, 0);

    // Back-to-back 0x55 then 0x0F with valid held: 0x2AA then 0x21E, no idle gap
    send(0, 8'h55);
    data_r[0] = 8'h0F;
    run_frame("b2b", 0, 20, 32'h87AAA, 2, 101, 0);

    // Reset asserted during data bit 3 (line bit 4) of 0xA5
    send(0, 8'hA5);
    valid_r[0] = 1'b0;
    watch(0, 45, 0, 0);
    chk("rst_pre_bits", obs & 32'h1F, 32'h0A);
    chk("rst_pre_busy", 32'(busy_w[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_async_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_async_done", 32'(done_w[0]), 32'd0);
    #3 reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 32'(ready_w[0]), 32'd1);
    chk("rst_release_tx", 32'(tx_w[0]), 32'd1);
    @(posedge clk);
    #1;

    // 0x3C after recovery -> 0x278
    send(0, 8'h3C);
    run_frame("post_rst_3c", 0, 10, 32'h278, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
